// File: rtl/rv_isa_pkg.sv
// Shared RV32I encoder definitions: instruction formats, base opcodes and immediate range limits.
// Used by the instruction encoder and its output queue.
package rv_isa_pkg;

  typedef enum logic [2:0] {
    FMT_R     = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6,
    FMT_ILL   = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int BIMM_MIN  = -4096;
  localparam int BIMM_MAX  = 4094;
  localparam int JIMM_MIN  = -1048576;
  localparam int JIMM_MAX  = 1048574;
  localparam int SHAMT_MAX = 31;

endpackage

// File: rtl/rv_enc_fifo.sv
// Encoder output queue of {addr,instr} words; head visible the cycle after the first push, zero when empty.
// Push is only legal when not full (caller gates on o_full); pop when not empty.
module rv_enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head_dat
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign o_empty    = (r_wr_ptr == r_rd_ptr);
  assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
  end

endmodule

// File: rtl/rv_instr_encoder.sv
// RV32I field-bundle encoder: combinational encode, address tag, queued in rv_enc_fifo; 1-cycle latency, in_ready = !full.
// Optional immediate range rejection when ENCODER_RANGE_CHECK_EN is defined; otherwise immediates truncate.
module rv_instr_encoder
  import rv_isa_pkg::*;
#(
  parameter int          DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        addr_load,
  input  logic [31:0] addr_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [7:0]  err_count
);

  fmt_e        w_fmt;
  logic [31:0] w_instr;
  logic        w_range_bad;
  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_reject;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_tag_addr;
  logic [63:0] w_head_dat;
  logic [31:0] r_addr;
  logic [7:0]  r_err;

  assign w_fmt = fmt_e'(in_fmt);

  always_comb begin
    w_instr = '0;
    case (w_fmt)
      FMT_R:     w_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I:     w_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S:     w_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B:     w_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_opcode};
      FMT_U:     w_instr = {in_imm[31:12], in_rd, in_opcode};
      FMT_J:     w_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      FMT_SHAMT: w_instr = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
      default:   w_instr = '0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [31:0] w_imm_s;
  assign w_imm_s = $signed(in_imm);

  always_comb begin
    w_range_bad = 1'b0;
    case (w_fmt)
      FMT_I, FMT_S: w_range_bad = (w_imm_s < IMM12_MIN) || (w_imm_s > IMM12_MAX);
      FMT_B:        w_range_bad = (w_imm_s < BIMM_MIN) || (w_imm_s > BIMM_MAX) || in_imm[0];
      FMT_J:        w_range_bad = (w_imm_s < JIMM_MIN) || (w_imm_s > JIMM_MAX) || in_imm[0];
      FMT_U:        w_range_bad = |in_imm[11:0];
      FMT_SHAMT:    w_range_bad = (w_imm_s < 0) || (w_imm_s > SHAMT_MAX);
      default:      w_range_bad = 1'b0;
    endcase
  end
`else
  assign w_range_bad = 1'b0;
`endif

  assign in_ready   = !w_full;
  assign w_accept   = in_valid && in_ready;
  assign w_reject   = w_accept && ((w_fmt == FMT_ILL) || w_range_bad);
  assign w_push     = w_accept && !w_reject;
  assign w_pop      = out_valid && out_ready;
  // A same-cycle reload tags the accepted bundle with the new address.
  assign w_tag_addr = addr_load ? addr_in : r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= RESET_ADDR;
      r_err  <= '0;
    end else begin
      if (w_push)         r_addr <= w_tag_addr + 32'd4;
      else if (addr_load) r_addr <= addr_in;
      if (w_reject && (r_err != 8'hFF)) r_err <= r_err + 8'd1;
    end
  end

  rv_enc_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_dat ({w_tag_addr, w_instr}),
    .i_pop      (w_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head_dat (w_head_dat)
  );

  assign out_valid = !w_empty;
  assign out_addr  = w_head_dat[63:32];
  assign out_instr = w_head_dat[31:0];
  assign err_count = r_err;

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed encodings, backpressure, address wrap, saturation, reset, random traffic.
// A negedge reference model keeps its own queue of {addr,instr} and compares every popped head.
module tb_rv_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        addr_load;
  logic [31:0] addr_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [7:0]  err_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv_instr_encoder #(.DEPTH(DEPTH), .RESET_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_fmt    (in_fmt),
    .in_opcode (in_opcode),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .addr_load (addr_load),
    .addr_in   (addr_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .err_count (err_count)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference encoding built from shifted fields.
  function automatic logic [31:0] enc(input logic [2:0] f, input logic [6:0] op,
                                      input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [4:0] rd, input logic [4:0] rs1,
                                      input logic [4:0] rs2, input logic [31:0] imm);
    logic [31:0] o, a3, a7, d, s1, s2, base_r;
    o  = {25'd0, op};
    a3 = {29'd0, f3};
    a7 = {25'd0, f7};
    d  = {27'd0, rd};
    s1 = {27'd0, rs1};
    s2 = {27'd0, rs2};
    base_r = (s1 << 15) | (a3 << 12) | o;
    case (f)
      3'd0: return (a7 << 25) | (s2 << 20) | base_r | (d << 7);
      3'd1: return ((imm & 32'hFFF) << 20) | base_r | (d << 7);
      3'd2: return (((imm >> 5) & 32'h7F) << 25) | (s2 << 20) | base_r | ((imm & 32'h1F) << 7);
      3'd3: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (s2 << 20) |
                   base_r | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      3'd4: return (imm & 32'hFFFF_F000) | (d << 7) | o;
      3'd5: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                   (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (d << 7) | o;
      3'd6: return (a7 << 25) | ((imm & 32'h1F) << 20) | base_r | (d << 7);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic out_of_range(input logic [2:0] f, input logic [31:0] imm);
`ifdef ENCODER_RANGE_CHECK_EN
    int v;
    v = int'($signed(imm));
    case (f)
      3'd1, 3'd2: return (v < -2048) || (v > 2047);
      3'd3:       return (v < -4096) || (v > 4094) || (v % 2 != 0);
      3'd5:       return (v < -1048576) || (v > 1048574) || (v % 2 != 0);
      3'd4:       return (imm % 4096) != 0;
      3'd6:       return (v < 0) || (v > 31);
      default:    return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard model, evaluated between edges with inputs stable.
  logic [63:0] sb[$];
  logic [31:0] m_addr = BASE;
  logic [7:0]  m_err  = 8'd0;
  logic        mon_en = 1'b0;
  logic        m_acc, m_pop, m_bad;
  logic [63:0] m_head;
  logic [31:0] m_tag;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("in_ready", in_ready, sb.size() < DEPTH);
      chk("out_valid", out_valid, sb.size() != 0);
      chk("err_count", err_count, m_err);
      if (reset) begin
        sb.delete();
        m_addr = BASE;
        m_err  = 8'd0;
      end else begin
        m_acc = in_valid && (sb.size() < DEPTH);
        m_pop = (sb.size() != 0) && out_ready;
        if (m_pop) begin
          m_head = sb.pop_front();
          chk("sb_instr", out_instr, m_head[31:0]);
          chk("sb_addr", out_addr, m_head[63:32]);
        end
        m_tag = addr_load ? addr_in : m_addr;
        if (m_acc) begin
          m_bad = (in_fmt == 3'd7) || out_of_range(in_fmt, in_imm);
          if (m_bad) begin
            if (m_err != 8'hFF) m_err = m_err + 8'd1;
            if (addr_load) m_addr = addr_in;
          end else begin
            sb.push_back({m_tag, enc(in_fmt, in_opcode, in_funct3, in_funct7,
                                     in_rd, in_rs1, in_rs2, in_imm)});
            m_addr = m_tag + 32'd4;
          end
        end else if (addr_load) begin
          m_addr = addr_in;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm,
                      input logic ld, input logic [31:0] la);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_fmt = f; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; addr_load = ld; addr_in = la;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (!ok && k >= 2) out_ready = 1'b1;
    end
    in_valid  = 1'b0;
    addr_load = 1'b0;
    if (!ok) chk("send_accept", ok, 1'b1);
  endtask

  task automatic check_head(input string t, input logic [31:0] ei, input logic [31:0] ea);
    @(negedge clk);
    chk({t, "_vld"}, out_valid, 1'b1);
    chk({t, "_instr"}, out_instr, ei);
    chk({t, "_addr"}, out_addr, ea);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick_imm();
    case ($urandom_range(0, 5))
      0: return 32'($signed($urandom_range(0, 80)) - 40);
      1: return $urandom;
      2: return 32'($urandom_range(0, 40));
      default:
        case ($urandom_range(0, 11))
          0: return 32'd2047;   1: return 32'd2048;
          2: return -32'd2048;  3: return -32'd2049;
          4: return 32'd4094;   5: return -32'd4096;
          6: return 32'd4096;   7: return 32'd1048574;
          8: return -32'd1048576; 9: return 32'd1048576;
          10: return 32'd31;    default: return 32'h0001_2000;
        endcase
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] nxt;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_fmt = 3'd0; in_opcode = 7'd0; in_funct3 = 3'd0;
    in_funct7 = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'd0;
    addr_load = 1'b0; addr_in = 32'd0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err", err_count, 8'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed encodings
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'd0);
    check_head("addi", 32'h0050_0093, BASE);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'd0);
    check_head("beq", 32'h0020_8463, BASE + 32'h4);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, -32'd4, 1'b0, 32'd0);
    check_head("sw", 32'hFE20_AE23, BASE + 32'h8);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, -32'd4, 1'b0, 32'd0);
    check_head("jal", 32'hFFDF_F0EF, BASE + 32'hC);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0, 32'd0);
    check_head("lui", 32'h1234_52B7, BASE + 32'h10);

    // Immediate just outside the 12-bit range
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'd0);
`ifdef ENCODER_RANGE_CHECK_EN
    @(negedge clk);
    chk("rng_err", err_count, 8'd1);
    chk("rng_not_queued", out_valid, 1'b0);
    @(posedge clk); #1;
    nxt = BASE + 32'h14;
`else
    check_head("rng_trunc", 32'h8000_0093, BASE + 32'h14);
    chk("rng_err", err_count, 8'd0);
    nxt = BASE + 32'h18;
`endif
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'd0);
    check_head("rng_next", 32'h0010_0093, nxt);

    // Address reload concurrent with accept, then wrap
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b1, 32'hFFFF_FFFC);
    check_head("wrap0", 32'h0070_0113, 32'hFFFF_FFFC);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 32'd9, 1'b0, 32'd0);
    check_head("wrap1", 32'h0090_0193, 32'h0000_0000);

    // Reload alone
    addr_load = 1'b1; addr_in = 32'h0000_8000;
    @(posedge clk); #1;
    addr_load = 1'b0;
    send(3'd0, 7'h33, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'd0);
    check_head("sub", 32'h4020_81B3, 32'h0000_8000);

    // Backpressure: fill, hold an extra bundle, then release
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      send(3'd6, 7'h13, 3'd1, 7'd0, 5'(i + 1), 5'd4, 5'd0, 32'(i + 3), 1'b0, 32'd0);
    @(negedge clk);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd9, 5'd9, 5'd0, 32'd99, 1'b0, 32'd0);
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("bp_drained", sb.size(), 0);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      out_ready = 1'($urandom_range(0, 1));
      send(3'($urandom_range(0, 7)), 7'($urandom), 3'($urandom), 7'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), pick_imm(),
           1'($urandom_range(0, 9) == 0), $urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("rand_drained", sb.size(), 0);

    // Error counter saturation with back-to-back illegal formats
    in_valid = 1'b1; in_fmt = 3'd7;
    repeat (270) @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("err_sat", err_count, 8'hFF);
    @(posedge clk); #1;

    // Reset with two entries queued and a bundle presented
    out_ready = 1'b0;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'd0);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2, 1'b0, 32'd0);
    in_valid = 1'b1; in_fmt = 3'd1; in_imm = 32'd3;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_vld", out_valid, 1'b0);
    chk("rst_mid_rdy", in_ready, 1'b1);
    chk("rst_mid_err", err_count, 8'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'd0);
    check_head("post_rst", 32'h0050_0093, BASE);

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
